regfile_commit_sequencer: RTL and testbench

//  Sequences ROB commit traffic onto the register file's single write port.

---
 rtl/regfile_commit_sequencer_pkg.sv | 20 ++
 rtl/regfile_commit_sequencer_fw_match.sv | 37 +++
 rtl/regfile_commit_sequencer.sv | 133 +++++++++++++
 tb/tb_regfile_commit_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_commit_sequencer_pkg.sv
// Shared configuration for the commit sequencer slice.
// Provides register-file widths, the commit FIFO geometry and a small helper
// that decides whether a commit slot actually produces a register write.
package regfile_commit_sequencer_pkg;

  localparam int DATA_LEN          = 32;
  localparam int REG_ADDR_LEN      = 5;
  localparam int COMMIT_FIFO_DEPTH = 4;
  localparam int COMMIT_PTR_LEN    = 2;

  localparam logic [REG_ADDR_LEN-1:0] ZERO_REG_ADDR = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // x0 is hardwired to zero, so a commit targeting it never needs a write.
  function automatic logic isWritable(input logic valid, input logic [REG_ADDR_LEN-1:0] rd);
    return valid && (rd != ZERO_REG_ADDR);
  endfunction

endpackage

// File: rtl/regfile_commit_sequencer_fw_match.sv
// commit_fw_match: DEPTH-way youngest-match priority select.
// Entries arrive in age order (index 0 = oldest). The youngest valid entry
// whose destination equals addr_i supplies the forwarded value.
// Ports:
//   addr_i   lookup register address (x0 never hits)
//   valid_i  per-entry occupancy, age ordered
//   rd_i     per-entry destination register, age ordered
//   data_i   per-entry value, age ordered
//   hit_o    some valid entry matches
//   data_o   value from the youngest matching entry
module commit_fw_match
  import regfile_commit_sequencer_pkg::*;
#(
  parameter int DEPTH = COMMIT_FIFO_DEPTH
) (
  input  logic [REG_ADDR_LEN-1:0]            addr_i,
  input  logic [DEPTH-1:0]                   valid_i,
  input  logic [DEPTH-1:0][REG_ADDR_LEN-1:0] rd_i,
  input  logic [DEPTH-1:0][DATA_LEN-1:0]     data_i,
  output logic                               hit_o,
  output logic [DATA_LEN-1:0]                data_o
);

  // Scanning oldest to youngest lets a later match override an earlier one,
  // so the final value is always the youngest match.
  always_comb begin
    hit_o  = FALSE;
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (rd_i[i] == addr_i) && (addr_i != ZERO_REG_ADDR)) begin
        hit_o  = TRUE;
        data_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/regfile_commit_sequencer.sv
// regfile_commit_sequencer: funnels up to two in-order ROB commits per cycle
// into a small FIFO and drains one register-file write per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global ready; all state holds while low
//   has_misbranch            register file ignores writes this cycle
//   c0_* / c1_*              commit slots (c0 older than c1)
//   commit_ready             room for two commits this cycle
//   wr_en / wr_rd / wr_data  register-file write port
//   fw_rs1_* / fw_rs2_*      issue-side forwarding of queued values
//   empty, count             FIFO occupancy
module regfile_commit_sequencer
  import regfile_commit_sequencer_pkg::*;
#(
  parameter int DEPTH = COMMIT_FIFO_DEPTH,
  parameter int PTR_W = COMMIT_PTR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    has_misbranch,
  input  logic                    c0_valid,
  input  logic [REG_ADDR_LEN-1:0] c0_rd,
  input  logic [DATA_LEN-1:0]     c0_data,
  input  logic                    c1_valid,
  input  logic [REG_ADDR_LEN-1:0] c1_rd,
  input  logic [DATA_LEN-1:0]     c1_data,
  output logic                    commit_ready,
  output logic                    wr_en,
  output logic [REG_ADDR_LEN-1:0] wr_rd,
  output logic [DATA_LEN-1:0]     wr_data,
  input  logic [REG_ADDR_LEN-1:0] fw_rs1_addr,
  input  logic [REG_ADDR_LEN-1:0] fw_rs2_addr,
  output logic                    fw_rs1_hit,
  output logic [DATA_LEN-1:0]     fw_rs1_data,
  output logic                    fw_rs2_hit,
  output logic [DATA_LEN-1:0]     fw_rs2_data,
  output logic                    empty,
  output logic [PTR_W:0]          count
);

  localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [PTR_W:0]          count_q, count_d;
  logic [REG_ADDR_LEN-1:0] rd_q   [DEPTH];
  logic [DATA_LEN-1:0]     data_q [DEPTH];

  logic                    enq0, enq1;
  logic [1:0]              enqCount;
  logic [PTR_W-1:0]        tailSlot1;

  logic [DEPTH-1:0]                   ageValid;
  logic [DEPTH-1:0][REG_ADDR_LEN-1:0] ageRd;
  logic [DEPTH-1:0][DATA_LEN-1:0]     ageData;

  assign empty        = (count_q == '0);
  assign count        = count_q;
  // Uses registered occupancy only, so a dequeue this cycle cannot open the gate early.
  assign commit_ready = (count_q <= READY_LIMIT);

  // Misbranch does not block enqueue: committed values are architectural.
  assign enq0      = !rst && rdy && commit_ready && isWritable(c0_valid, c0_rd);
  assign enq1      = !rst && rdy && commit_ready && isWritable(c1_valid, c1_rd);
  assign enqCount  = {1'b0, enq0} + {1'b0, enq1};
  // c1 lands after c0, or in c0's slot when c0 is skipped.
  assign tailSlot1 = tail_q + PTR_W'(enq0);

  assign wr_en   = !empty && rdy && !has_misbranch && !rst;
  assign wr_rd   = rd_q[head_q];
  assign wr_data = data_q[head_q];

  assign head_d  = head_q + PTR_W'(wr_en);
  assign tail_d  = tail_q + PTR_W'(enqCount);
  assign count_d = count_q + (PTR_W+1)'(enqCount) - (PTR_W+1)'(wr_en);

  // Pointer and occupancy state; rdy gating is already folded into enq/wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (enq0) begin
      rd_q[tail_q]   <= c0_rd;
      data_q[tail_q] <= c0_data;
    end
    if (enq1) begin
      rd_q[tailSlot1]   <= c1_rd;
      data_q[tailSlot1] <= c1_data;
    end
  end

  // Re-order the circular buffer oldest-first so the matcher can prefer the youngest.
  always_comb begin
    ageValid = '0;
    ageRd    = '0;
    ageData  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ageValid[i] = ((PTR_W+1)'(i) < count_q);
      ageRd[i]    = rd_q[head_q + PTR_W'(i)];
      ageData[i]  = data_q[head_q + PTR_W'(i)];
    end
  end

  commit_fw_match #(.DEPTH(DEPTH)) u_fw_rs1 (
    .addr_i  (fw_rs1_addr),
    .valid_i (ageValid),
    .rd_i    (ageRd),
    .data_i  (ageData),
    .hit_o   (fw_rs1_hit),
    .data_o  (fw_rs1_data)
  );

  commit_fw_match #(.DEPTH(DEPTH)) u_fw_rs2 (
    .addr_i  (fw_rs2_addr),
    .valid_i (ageValid),
    .rd_i    (ageRd),
    .data_i  (ageData),
    .hit_o   (fw_rs2_hit),
    .data_o  (fw_rs2_data)
  );

endmodule

// File: tb/tb_regfile_commit_sequencer.sv
// Self-checking bench for regfile_commit_sequencer: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_regfile_commit_sequencer;

  logic        clk = 1'b0;
  logic        rst, rdy, has_misbranch;
  logic        c0_valid, c1_valid;
  logic [4:0]  c0_rd, c1_rd;
  logic [31:0] c0_data, c1_data;
  logic        commit_ready, wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [4:0]  fw_rs1_addr, fw_rs2_addr;
  logic        fw_rs1_hit, fw_rs2_hit;
  logic [31:0] fw_rs1_data, fw_rs2_data;
  logic        empty;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t modelQ[$];
  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  regfile_commit_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .has_misbranch (has_misbranch),
    .c0_valid      (c0_valid),
    .c0_rd         (c0_rd),
    .c0_data       (c0_data),
    .c1_valid      (c1_valid),
    .c1_rd         (c1_rd),
    .c1_data       (c1_data),
    .commit_ready  (commit_ready),
    .wr_en         (wr_en),
    .wr_rd         (wr_rd),
    .wr_data       (wr_data),
    .fw_rs1_addr   (fw_rs1_addr),
    .fw_rs2_addr   (fw_rs2_addr),
    .fw_rs1_hit    (fw_rs1_hit),
    .fw_rs1_data   (fw_rs1_data),
    .fw_rs2_hit    (fw_rs2_hit),
    .fw_rs2_data   (fw_rs2_data),
    .empty         (empty),
    .count         (count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ry, input logic mis,
                               input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] f1, input logic [4:0] f2);
    rst = r; rdy = ry; has_misbranch = mis;
    c0_valid = v0; c0_rd = a0; c0_data = d0;
    c1_valid = v1; c1_rd = a1; c1_data = d1;
    fw_rs1_addr = f1; fw_rs2_addr = f2;
  endtask

  task automatic idle(input logic [4:0] f1, input logic [4:0] f2);
    applyStimulus(0, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, f1, f2);
  endtask

  // Youngest queued value for a register; x0 never forwards.
  task automatic modelLookup(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = 32'h0;
    if (addr != 5'd0) begin
      for (int i = modelQ.size() - 1; i >= 0; i--) begin
        if (modelQ[i].rd == addr) begin
          hit = 1'b1;
          data = modelQ[i].data;
          break;
        end
      end
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic runCycle(input bit fullCheck);
    int          size;
    logic        expWr, expReady, h1, h2;
    logic [31:0] e1, e2;
    entry_t      e;
    @(negedge clk);
    size     = modelQ.size();
    expReady = ((4 - size) >= 2);
    expWr    = (size > 0) && rdy && !has_misbranch && !rst;
    checkOutput("wr_en", {31'b0, wr_en}, {31'b0, expWr});
    if (fullCheck) begin
      checkOutput("count", {29'b0, count}, 32'(size));
      checkOutput("empty", {31'b0, empty}, {31'b0, size == 0});
      checkOutput("commit_ready", {31'b0, commit_ready}, {31'b0, expReady});
      if (size > 0) begin
        checkOutput("wr_rd", {27'b0, wr_rd}, {27'b0, modelQ[0].rd});
        checkOutput("wr_data", wr_data, modelQ[0].data);
      end
      modelLookup(fw_rs1_addr, h1, e1);
      modelLookup(fw_rs2_addr, h2, e2);
      checkOutput("fw_rs1_hit", {31'b0, fw_rs1_hit}, {31'b0, h1});
      checkOutput("fw_rs2_hit", {31'b0, fw_rs2_hit}, {31'b0, h2});
      if (h1) checkOutput("fw_rs1_data", fw_rs1_data, e1);
      if (h2) checkOutput("fw_rs2_data", fw_rs2_data, e2);
    end
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
    end else if (rdy) begin
      if (expWr) void'(modelQ.pop_front());
      if (expReady) begin
        if (c0_valid && c0_rd != 5'd0) begin
          e.rd = c0_rd; e.data = c0_data; modelQ.push_back(e);
        end
        if (c1_valid && c1_rd != 5'd0) begin
          e.rd = c1_rd; e.data = c1_data; modelQ.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    // Reset for two cycles; only wr_en is defined before the first edge.
    applyStimulus(1, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    runCycle(0);
    runCycle(1);

    // Dual commit drains in order.
    applyStimulus(0, 1, 0, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 5'd5, 5'd6);
    runCycle(1);
    repeat (3) begin idle(5'd5, 5'd6); runCycle(1); end

    // x0 is skipped, only x7 lands.
    applyStimulus(0, 1, 0, 1, 5'd0, 32'hFF, 1, 5'd7, 32'h33, 5'd0, 5'd7);
    runCycle(1);
    repeat (2) begin idle(5'd0, 5'd7); runCycle(1); end

    // Fill to three under misbranch, then one dequeue reopens commit_ready.
    applyStimulus(0, 1, 1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2, 5'd1, 5'd2);
    runCycle(1);
    applyStimulus(0, 1, 1, 0, 5'd0, 32'h0, 1, 5'd3, 32'hA3, 5'd3, 5'd2);
    runCycle(1);
    applyStimulus(0, 1, 1, 1, 5'd4, 32'hBAD, 1, 5'd4, 32'hBAD, 5'd4, 5'd3);
    runCycle(1);
    idle(5'd1, 5'd4);
    runCycle(1);
    applyStimulus(0, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd2, 5'd3);
    runCycle(1);
    repeat (3) begin idle(5'd2, 5'd3); runCycle(1); end

    // Misbranch holds the write a cycle; rdy low freezes everything.
    applyStimulus(0, 1, 0, 1, 5'd8, 32'h44, 0, 5'd0, 32'h0, 5'd8, 5'd0);
    runCycle(1);
    applyStimulus(0, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd8, 5'd0);
    runCycle(1);
    repeat (2) begin
      applyStimulus(0, 0, 0, 1, 5'd9, 32'h55, 1, 5'd10, 32'h66, 5'd8, 5'd9);
      runCycle(1);
    end
    repeat (2) begin idle(5'd8, 5'd9); runCycle(1); end

    // Youngest of two x9 entries forwards; hits clear after draining.
    applyStimulus(0, 1, 1, 1, 5'd9, 32'h1, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    runCycle(1);
    applyStimulus(0, 1, 1, 1, 5'd9, 32'h2, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    runCycle(1);
    applyStimulus(0, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd0);
    runCycle(1);
    repeat (3) begin idle(5'd9, 5'd9); runCycle(1); end

    // Randomized traffic, including protocol-error enqueues and mid-drain resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 85),
                    ($urandom_range(0, 99) < 25),
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      runCycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
